// File: rtl/ap_txn_profiler.sv
// ap_txn_profiler
// Watches the ap_ctrl_hs handshake of one HLS block-level kernel and turns
// every transaction into a record {start_ts, latency, interval, stall}.
// Accepted starts wait in a small in-order queue until their done arrives.
// Finished records are buffered in a show-ahead FIFO that is drained over
// valid/ready.
// Optional build macro: PROFILER_STALL_CNT_EN enables the per-transaction
// stall counter. Without it rec_stall reads 0 and the port is kept.
module ap_txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int Q_DEPTH    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_start_ts,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] rec_stall,
  output logic [CNT_W-1:0] txn_count,
  output logic [15:0]      drop_count,
  output logic             err_q_ovf,
  output logic             err_orphan,
  output logic             drained
);

  localparam int QA_W = $clog2(Q_DEPTH);
  localparam int FA_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [QA_W-1:0]  QPTR_ONE = QA_W'(1);
  localparam logic [QA_W:0]    QCNT_ONE = (QA_W + 1)'(1);
  localparam logic [QA_W:0]    Q_FULL   = (QA_W + 1)'(Q_DEPTH);
  localparam logic [FA_W-1:0]  FPTR_ONE = FA_W'(1);
  localparam logic [FA_W:0]    FCNT_ONE = (FA_W + 1)'(1);
  localparam logic [FA_W:0]    F_FULL   = (FA_W + 1)'(FIFO_DEPTH);

  // Saturating increment for CNT_W-wide statistics.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Saturating increment for the 16-bit drop counter.
  function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Control state
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] last_acc_ts;
  logic             have_prev;
  logic [CNT_W-1:0] stall_cap;

  // Start queue
  logic [CNT_W-1:0] q_ts [Q_DEPTH];
  logic [CNT_W-1:0] q_iv [Q_DEPTH];
  logic [CNT_W-1:0] q_st [Q_DEPTH];
  logic [QA_W-1:0]  q_rd_ptr;
  logic [QA_W-1:0]  q_wr_ptr;
  logic [QA_W:0]    q_cnt;

  // Record FIFO
  logic [CNT_W-1:0] f_ts  [FIFO_DEPTH];
  logic [CNT_W-1:0] f_lat [FIFO_DEPTH];
  logic [CNT_W-1:0] f_iv  [FIFO_DEPTH];
  logic [CNT_W-1:0] f_st  [FIFO_DEPTH];
  logic [FA_W-1:0]  f_rd_ptr;
  logic [FA_W-1:0]  f_wr_ptr;
  logic [FA_W:0]    f_cnt;

  // Stage p0: handshake decode and record assembly
  logic             accept_p0;
  logic             retire_p0;
  logic             acc_en_p0;
  logic             q_empty_p0;
  logic             q_full_p0;
  logic             q_pop_p0;
  logic             q_push_p0;
  logic             ovf_p0;
  logic             orph_p0;
  logic [CNT_W-1:0] iv_p0;
  logic             vld_p0;
  logic [CNT_W-1:0] rec_ts_p0;
  logic [CNT_W-1:0] rec_lat_p0;
  logic [CNT_W-1:0] rec_iv_p0;
  logic [CNT_W-1:0] rec_st_p0;
  logic             f_empty_p0;
  logic             f_full_p0;
  logic             f_rd_p0;
  logic             f_wr_p0;
  logic             drop_p0;

  // Free-running timestamp base; wraps at 2^CNT_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + CNT_ONE;
  end

`ifdef PROFILER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Counts cycles the kernel was asked to start but was not ready; cleared by the accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         stall_cnt <= '0;
    else if (accept_p0) stall_cnt <= '0;
    else if (ap_start)  stall_cnt <= sat_inc_cnt(stall_cnt);
  end

  assign stall_cap = stall_cnt;
`else
  assign stall_cap = '0;
`endif

  // Decide queue push/pop and assemble the record for this cycle.
  always_comb begin
    accept_p0  = ap_start & ap_ready;
    retire_p0  = ap_done & ap_continue;
    // Only RUN queues new starts; DRAIN and DONE ignore them silently.
    acc_en_p0  = accept_p0 & (state == ST_RUN);
    q_empty_p0 = (q_cnt == '0);
    q_full_p0  = (q_cnt == Q_FULL);
    iv_p0      = have_prev ? (cycle_cnt - last_acc_ts) : '0;
    vld_p0     = 1'b0;
    q_pop_p0   = 1'b0;
    q_push_p0  = 1'b0;
    ovf_p0     = 1'b0;
    orph_p0    = 1'b0;
    rec_ts_p0  = cycle_cnt;
    rec_iv_p0  = iv_p0;
    rec_st_p0  = stall_cap;
    if (retire_p0) begin
      if (!q_empty_p0) begin
        // Oldest start retires; a same-cycle accept takes the freed slot.
        vld_p0    = 1'b1;
        q_pop_p0  = 1'b1;
        q_push_p0 = acc_en_p0;
        rec_ts_p0 = q_ts[q_rd_ptr];
        rec_iv_p0 = q_iv[q_rd_ptr];
        rec_st_p0 = q_st[q_rd_ptr];
      end else if (acc_en_p0) begin
        // Combinational kernel: start and done in one cycle, latency 0.
        vld_p0 = 1'b1;
      end else begin
        orph_p0 = 1'b1;
      end
    end else if (acc_en_p0) begin
      if (q_full_p0) ovf_p0    = 1'b1;
      else           q_push_p0 = 1'b1;
    end
    rec_lat_p0 = cycle_cnt - rec_ts_p0;
  end

  // FIFO read/write arbitration; a read frees the slot for a write when full.
  always_comb begin
    f_empty_p0 = (f_cnt == '0);
    f_full_p0  = (f_cnt == F_FULL);
    f_rd_p0    = !f_empty_p0 & rec_ready;
    f_wr_p0    = vld_p0 & (!f_full_p0 | f_rd_p0);
    drop_p0    = vld_p0 & f_full_p0 & !f_rd_p0;
  end

  // Start queue pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_rd_ptr <= '0;
      q_wr_ptr <= '0;
      q_cnt    <= '0;
    end else begin
      if (q_pop_p0)  q_rd_ptr <= q_rd_ptr + QPTR_ONE;
      if (q_push_p0) q_wr_ptr <= q_wr_ptr + QPTR_ONE;
      case ({q_push_p0, q_pop_p0})
        2'b10:   q_cnt <= q_cnt + QCNT_ONE;
        2'b01:   q_cnt <= q_cnt - QCNT_ONE;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Start queue payload; contents are meaningless outside the occupied window.
  always_ff @(posedge clock) begin
    if (q_push_p0) begin
      q_ts[q_wr_ptr] <= cycle_cnt;
      q_iv[q_wr_ptr] <= iv_p0;
      q_st[q_wr_ptr] <= stall_cap;
    end
  end

  // Stage p1: record FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_rd_ptr <= '0;
      f_wr_ptr <= '0;
      f_cnt    <= '0;
    end else begin
      if (f_rd_p0) f_rd_ptr <= f_rd_ptr + FPTR_ONE;
      if (f_wr_p0) f_wr_ptr <= f_wr_ptr + FPTR_ONE;
      case ({f_wr_p0, f_rd_p0})
        2'b10:   f_cnt <= f_cnt + FCNT_ONE;
        2'b01:   f_cnt <= f_cnt - FCNT_ONE;
        default: f_cnt <= f_cnt;
      endcase
    end
  end

  // Record FIFO payload.
  always_ff @(posedge clock) begin
    if (f_wr_p0) begin
      f_ts[f_wr_ptr]  <= rec_ts_p0;
      f_lat[f_wr_ptr] <= rec_lat_p0;
      f_iv[f_wr_ptr]  <= rec_iv_p0;
      f_st[f_wr_ptr]  <= rec_st_p0;
    end
  end

  // Remember whether an earlier accept exists, for the interval field.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         have_prev <= 1'b0;
    else if (acc_en_p0) have_prev <= 1'b1;
  end

  // Timestamp of the previous accept; only read once have_prev is set.
  always_ff @(posedge clock) begin
    if (acc_en_p0) last_acc_ts <= cycle_cnt;
  end

  // Transaction/drop statistics and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txn_count  <= '0;
      drop_count <= '0;
      err_q_ovf  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (vld_p0)  txn_count  <= sat_inc_cnt(txn_count);
      if (drop_p0) drop_count <= sat_inc_16(drop_count);
      if (ovf_p0)  err_q_ovf  <= 1'b1;
      if (orph_p0) err_orphan <= 1'b1;
    end
  end

  // RUN -> DRAIN on finish; DRAIN -> DONE once nothing is pending; DONE is terminal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (finish) state <= ST_DRAIN;
        ST_DRAIN: if (q_empty_p0 && f_empty_p0) state <= ST_DONE;
        default:  state <= state;
      endcase
    end
  end

  // Head fields are forced to zero while the FIFO is empty so reset shows all-zero outputs.
  assign rec_valid    = !f_empty_p0;
  assign rec_start_ts = rec_valid ? f_ts[f_rd_ptr]  : '0;
  assign rec_latency  = rec_valid ? f_lat[f_rd_ptr] : '0;
  assign rec_interval = rec_valid ? f_iv[f_rd_ptr]  : '0;
  assign rec_stall    = rec_valid ? f_st[f_rd_ptr]  : '0;
  assign drained      = (state == ST_DONE);

endmodule
